// File: rtl/sram_pkg.sv
// Shared types and default sizing for the register file and its clear sequencer.
package sram_pkg;

  localparam int DEF_DATA_W = 15;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/sram_clr_seq.sv
// Clear sequencer: walks an index over every entry, one per cycle, then pulses done.
module sram_clr_seq
  import sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] idx,
  output logic              idx_we
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_done;
  logic              w_last;

  assign w_last = (r_state == ST_CLEAR) && (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // clr_req is only looked at in IDLE, so holding it high cannot extend a clear
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clr_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_last)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == ST_CLEAR);
    idx_we = (r_state == ST_CLEAR);
    done   = r_done;
    idx    = r_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (r_state == ST_IDLE || w_last) r_idx <= '0;
      else                              r_idx <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_regfile.sv
// Two-read / one-write register file with optional write forwarding,
// optional hardwired-zero entry 0 and a sequenced clear-all.
module sram_regfile
  import sram_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_busy;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_clr_we;
  logic              w_wr_ok;

  sram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (w_busy),
    .done    (clr_done),
    .idx     (w_clr_idx),
    .idx_we  (w_clr_we)
  );

  assign clr_busy = w_busy;

  function automatic logic addr_wr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // rst_n gates forwarding so reads stay zero for the whole reset window;
  // a clear request in the same cycle wins over the write
  assign w_wr_ok = rst_n && we && !w_busy && !clr_req && addr_wr_ok(wa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_clr_we && (w_clr_idx == ADDR_W'(i)))  r_mem[i] <= '0;
        else if (w_wr_ok && (wa == ADDR_W'(i)))    r_mem[i] <= wd;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == ADDR_W'(i)) v = r_mem[i];
    if ((BYPASS != 0) && w_wr_ok && (wa == a)) v = wd;
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rd1 = rd_sel(ra1);
    rd2 = rd_sel(ra2);
  end

endmodule

// File: tb/tb_sram_regfile.sv
// Randomized + directed bench for sram_regfile: three parameter variants driven
// in lockstep and compared against an array-based reference model.
module tb_sram_regfile;

  localparam int DEPTH = 7;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ra1, ra2, wa;
  logic [14:0] wd;
  logic        we, clr_req;

  logic [14:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;

  // a: BYPASS=1, b: BYPASS=0, c: ZERO_REG=1
  sram_regfile #(.BYPASS(1), .ZERO_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .wa(wa), .wd(wd), .we(we), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));
  sram_regfile #(.BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .wa(wa), .wd(wd), .we(we), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));
  sram_regfile #(.BYPASS(1), .ZERO_REG(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_c), .rd2(rd2_c),
    .wa(wa), .wd(wd), .we(we), .clr_req(clr_req), .clr_busy(busy_c), .clr_done(done_c));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [14:0] mem [3][8];
  int          clr_left;
  int          clr_pos;
  logic        done_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) mem[k][i] = '0;
    clr_left = 0;
    clr_pos  = 0;
    done_exp = 1'b0;
  endtask

  function automatic logic [14:0] exp_rd(input int k, input logic [2:0] ra);
    if (!rst_n) return '0;
    if (int'(ra) >= DEPTH) return '0;
    if (k == 2 && ra == 3'd0) return '0;
    if (k != 1 && clr_left == 0 && !clr_req && we && wa == ra) return wd;
    return mem[k][ra];
  endfunction

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (clr_left > 0) begin
      for (int k = 0; k < 3; k++) mem[k][clr_pos] = '0;
      clr_pos++;
      clr_left--;
      if (clr_left == 0) nd = 1'b1;
    end else if (clr_req) begin
      clr_left = DEPTH;
      clr_pos  = 0;
    end else if (we && int'(wa) < DEPTH) begin
      for (int k = 0; k < 3; k++)
        if (!(k == 2 && wa == 3'd0)) mem[k][wa] = wd;
    end
    done_exp = nd;
  endtask

  task automatic check_all();
    logic bexp;
    bexp = (clr_left > 0);
    chk("rd1_a", 32'(rd1_a), 32'(exp_rd(0, ra1)));
    chk("rd2_a", 32'(rd2_a), 32'(exp_rd(0, ra2)));
    chk("rd1_b", 32'(rd1_b), 32'(exp_rd(1, ra1)));
    chk("rd2_b", 32'(rd2_b), 32'(exp_rd(1, ra2)));
    chk("rd1_c", 32'(rd1_c), 32'(exp_rd(2, ra1)));
    chk("rd2_c", 32'(rd2_c), 32'(exp_rd(2, ra2)));
    chk("busy_a", 32'(busy_a), 32'(bexp));
    chk("busy_b", 32'(busy_b), 32'(bexp));
    chk("busy_c", 32'(busy_c), 32'(bexp));
    chk("done_a", 32'(done_a), 32'(done_exp));
    chk("done_b", 32'(done_b), 32'(done_exp));
    chk("done_c", 32'(done_c), 32'(done_exp));
  endtask

  // drive one cycle: inputs settle, combinational check, clock edge, model update
  task automatic step(input logic w, input logic [2:0] a, input logic [14:0] d,
                      input logic [2:0] r1, input logic [2:0] r2, input logic c);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; clr_req = c;
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rnd_step(input int clr_pct);
    step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 15'($urandom),
         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
         1'(int'($urandom_range(0, 99)) < clr_pct));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step(1'b1, 3'd3, 15'h1111, 3'd3, 3'($urandom_range(0, 7)), 1'b0);
    step(1'b0, 3'd0, 15'h0, 3'd1, 3'd6, 1'b1);
    rst_n = 1'b1;
  endtask

  int busy_cnt, done_cnt;

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; clr_req = 1'b0;
    do_reset();

    // basic write then read; out-of-range read
    step(1'b1, 3'd3, 15'h1234, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 15'h0,    3'd3, 3'd7, 1'b0);
    // same-cycle forwarding vs. old value
    step(1'b1, 3'd5, 15'h7FFF, 3'd5, 3'd5, 1'b0);
    step(1'b0, 3'd0, 15'h0,    3'd5, 3'd5, 1'b0);
    // out-of-range write discarded
    step(1'b1, 3'd7, 15'h2222, 3'd7, 3'd7, 1'b0);
    // zero register write
    step(1'b1, 3'd0, 15'h0055, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 15'h0,    3'd0, 3'd0, 1'b0);

    // fill 1..7, clear with writes attempted throughout
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 15'(i + 1), 3'(i), 3'd0, 1'b0);
    step(1'b0, 3'd0, 15'h0, 3'd0, 3'd6, 1'b1);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      step(1'b1, 3'd2, 15'h00AA, 3'd0, 3'd6, 1'b0);
    end
    chk("clr_len", 32'(busy_cnt), 32'(DEPTH));
    chk("done_cnt", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 15'h0, 3'(i), 3'(7 - i), 1'b0);

    // clear request together with write: write dropped
    step(1'b1, 3'd4, 15'h0333, 3'd4, 3'd4, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'd0, 15'h0, 3'd4, 3'd3, 1'b0);

    // clr_req held high: no extension, restart right after done
    for (int i = 0; i < 3 * DEPTH; i++) rnd_step(100);
    for (int i = 0; i < DEPTH + 2; i++) rnd_step(0);

    // reset in the middle of a clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 15'(16'h0100 + i), 3'(i), 3'd6, 1'b0);
    step(1'b0, 3'd0, 15'h0, 3'd0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 15'h0, 3'd1, 3'd6, 1'b0);
    step(1'b0, 3'd0, 15'h0, 3'd2, 3'd6, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 15'h0, 3'(i), 3'(7 - i), 1'b0);

    // random traffic
    for (int i = 0; i < 1500; i++) rnd_step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_regfile.md
SRAM_REGFILE -- requirements
Module: sram_regfile

Interface
REQ-001 Parameter DATA_W, default 15: entry width in bits.
REQ-002 Parameter ADDR_W, default 3: address width for all ports.
REQ-003 Parameter DEPTH, default 7: implemented entries, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding.
REQ-005 Parameter ZERO_REG, default 0: 1 hardwires entry 0 to zero.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 ra1  input  ADDR_W  read address, port 1.
REQ-009 ra2  input  ADDR_W  read address, port 2.
REQ-010 rd1  output  DATA_W  read data, port 1.
REQ-011 rd2  output  DATA_W  read data, port 2.
REQ-012 wa  input  ADDR_W  write address.
REQ-013 wd  input  DATA_W  write data.
REQ-014 we  input  1  write enable.
REQ-015 clr_req  input  1  request clear of all entries.
REQ-016 clr_busy  output  1  clear sequence in progress.
REQ-017 clr_done  output  1  one-cycle pulse, clear finished.

Function
REQ-018 Reads SHALL be combinational: rdN = entry[raN] in the same cycle, zero latency.
REQ-019 Reads with raN >= DEPTH SHALL return all-zero.
REQ-020 Writes SHALL update entry[wa] <= wd on the rising clk edge when we=1 and the FSM is IDLE.
REQ-021 Writes with wa >= DEPTH SHALL be discarded without side effects.
REQ-022 With BYPASS=1, IDLE, we=1, wa=raN and wa < DEPTH, rdN SHALL equal wd in the same cycle.
REQ-023 With BYPASS=0, rdN SHALL show the old value until the edge after the write.
REQ-024 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 return zero, and entry 0 is never forwarded.
REQ-025 Both read ports SHALL be independent; ra1=ra2 returns identical data on both.
REQ-026 The FSM SHALL have two states: IDLE and CLEAR.
REQ-027 IDLE with clr_req=1 at an edge SHALL move to CLEAR and load the clear index to 0.
REQ-028 In CLEAR, each edge SHALL zero entry[index] and increment index.
REQ-029 At the edge that zeros entry DEPTH-1, the FSM SHALL return to IDLE; clr_done SHALL be 1 for exactly the following cycle.
REQ-030 A clear SHALL therefore take exactly DEPTH cycles; clr_busy SHALL be 1 in exactly those cycles.
REQ-031 In CLEAR, we SHALL be ignored and dropped; it is not queued and bypass is disabled.
REQ-032 In CLEAR, reads SHALL return current storage: cleared entries return 0, uncleared entries return old data.
REQ-033 If clr_req and we are both 1 in IDLE, the write SHALL be dropped and the clear started.
REQ-034 clr_req asserted in CLEAR, or held high, SHALL NOT restart or extend the sequence.
REQ-035 clr_req held high after clr_done SHALL start a new clear on the first IDLE edge.

Reset
REQ-036 rst_n=0 SHALL immediately zero all entries, set the FSM to IDLE, the index to 0, and clr_busy and clr_done to 0.
REQ-037 Reset during CLEAR SHALL abort it with no clr_done pulse.
REQ-038 rd1 and rd2 SHALL read 0 for every address while rst_n=0 and after release until written.

Structure
REQ-039 The FSM state encoding (IDLE, CLEAR) SHALL be defined in the shared package sram_pkg together with default width and depth constants.
REQ-040 The clear-sequencer FSM and index counter SHALL be one sub-module, sram_clr_seq, with ports clk, rst_n, clr_req, busy, done, idx, and idx_we.
REQ-041 Storage, read muxing, bypass and write gating SHALL stay in sram_regfile.

Verification
REQ-042 Default parameters: write 15'h1234 to address 3, then the next cycle ra1=3 -> rd1=15'h1234; ra2=7 -> rd2=0.
REQ-043 BYPASS=1: we=1, wa=5, wd=15'h7FFF, ra1=5 in the same cycle -> rd1=15'h7FFF before the edge. BYPASS=0 -> rd1 shows the old value, then 15'h7FFF after the edge.
REQ-044 Fill entries 0-6 with 1..7, pulse clr_req -> clr_busy high for 7 cycles; mid-clear ra1=0 -> 0 and ra2=6 -> 7; clr_done pulses once; afterwards all reads return 0.
REQ-045 In CLEAR, we=1, wa=2, wd=15'h00AA -> after clr_done, entry 2 reads 0.
REQ-046 ZERO_REG=1: write 15'h0055 to address 0 -> rd1 reads 0 both same-cycle and next-cycle.
REQ-047 Assert rst_n=0 at cycle 3 of a clear -> clr_busy drops immediately, no clr_done, all entries read 0.
